rns_add_scheduler: RTL and testbench
====================================

Name: rns_add_scheduler

Overview:
- Shares one modular residue adder among NUM_REQ requesters for a single RNS channel of modulus MODULUS.
- Round-robin arbiter plus a 4-state sequencer. The sequencer accepts one operand pair, forms the 5-bit sum, reduces it mod MODULUS, and holds the tagged result until the consumer takes it.
- Sits between the per-lane RNS operand producers and the channel result bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal ceil(log2(NUM_REQ)), minimum 1.
- MODULUS, 15, channel modulus (2..16); 16 gives plain 4-bit wrap-around.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  one-hot grant/accept; req i accepted on an edge where req_valid[i] & req_ready[i].
- req_a  in  4*NUM_REQ  packed operand A; requester i uses bits [4i+3:4i].
- req_b  in  4*NUM_REQ  packed operand B, same packing.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_data  out  4  (a+b) mod MODULUS.
- res_id  out  ID_W  index of the requester that produced res_data.
- busy  out  1  high in any state other than IDLE.
- op_count  out  8  completed results (res handshakes), wraps 255->0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pointer last=NUM_REQ-1, so requester 0 has first priority; res_valid=0, res_data=0, res_id=0, op_count=0, busy=0, req_ready=0. An operation in flight is dropped and no result is emitted.
- States:
  - IDLE: req_ready is combinational, one-hot to the first i with req_valid[i] set, searching last+1, last+2, ... mod NUM_REQ. If any request is valid, on the edge: latch a, b and id; last<=id; go to ADD. Otherwise stay in IDLE. req_ready is 0 in all other states.
  - ADD: sum[4:0] <= a + b (a 4-bit carry-lookahead add with carry-out kept); go to RED.
  - RED: res_data <= (sum >= MODULUS) ? sum - MODULUS : sum[3:0]; res_id <= id; res_valid <= 1; go to OUT.
  - OUT: hold res_valid, res_data and res_id stable. On an edge with res_ready=1: res_valid <= 0; op_count++; go to IDLE.
- Latency: accept on edge k; res_valid is high after edge k+2.
- Throughput: with res_ready held at 1, at most one operation per 4 cycles. The next accept occurs on edge k+4.
- Operands are residues < MODULUS. Single subtraction is then sufficient because sum <= 2*MODULUS-2.
- Out-of-range operands:
  - Result is sum minus at most one MODULUS, truncated to 4 bits.
  - The result is not guaranteed to be a residue.
  - See Optional Feature for flagging.
- Requester dropping req_valid while not granted: no effect; there is no request memory.
- Request arriving in a non-IDLE state: it waits; it is not accepted until IDLE.
- res_ready high outside OUT: ignored.
- op_count wraps silently.
- busy = (state != IDLE).

Optional Feature:
- Macro RNS_RANGE_CHECK_EN.
- When defined:
  - Adds output res_err (1 bit, reset 0).
  - In RED, res_err <= (a >= MODULUS) | (b >= MODULUS). It is held with res_data and cleared with res_valid.
  - res_data is computed identically.
- When undefined: no res_err port and no compare logic.

Test Plan:
- MODULUS=15, single request: req_valid=0001, a=9, b=8. Required response:
  - req_ready=0001 in that cycle.
  - After 2 edges: res_valid=1, res_data=2, res_id=0.
  - op_count=1 after the handshake.
- MODULUS=15, all four requesters valid continuously with distinct operands, res_ready=1. Grant order must be 0,1,2,3,0; res_id follows the same order; one result every 4 cycles.
- Back-pressure: res_ready=0 for 10 cycles in OUT.
  - res_valid, res_data and res_id stay stable and req_ready stays 0000.
  - Raising res_ready completes the handshake; the next grant comes on the following cycle.
- Boundaries, MODULUS=15:
  - 7+7 must give 14 (no subtract).
  - 7+8 must give 0 (exactly MODULUS).
  - 14+14 must give 13.
- Boundary, MODULUS=16: 15+1 must give 0.
- Reset in RED: assert rst. Required response:
  - res_valid=0 immediately, asynchronously.
  - After release: IDLE, op_count=0, requester 0 has priority, and no stale result appears.
- With RNS_RANGE_CHECK_EN, MODULUS=7, a=9, b=1: res_err=1 and res_data=3. With a=3, b=4: res_err=0 and res_data=0.

Source files
------------

// File: rtl/rns_add_scheduler.sv
// rtl/rns_add_scheduler.sv - round-robin shared residue adder for one RNS channel (optional RNS_RANGE_CHECK_EN adds res_err)
module rns_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MODULUS = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [3:0]           res_data,
    output logic [ID_W-1:0]      res_id,
    output logic                 busy,
    output logic [7:0]           op_count
`ifdef RNS_RANGE_CHECK_EN
    ,
    output logic                 res_err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_RED  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;
    localparam logic [4:0] MOD5   = 5'(MODULUS);

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] id_q;
    logic [3:0]      a_q, b_q;
    logic [4:0]      sum_q;
    logic            res_valid_q;
    logic [3:0]      res_data_q;
    logic [ID_W-1:0] res_id_q;
    logic [7:0]      op_count_q;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] scan_idx;
    logic [4:0]      cla_sum;
    logic [4:0]      red_sub;
    logic [3:0]      red_data;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
        end
    end

    // Grant is only offered while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && !rst && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // 4-bit carry-lookahead add with carry-out kept as bit 4
    always_comb begin
        logic [3:0] g, p;
        logic [4:0] c;
        g    = a_q & b_q;
        p    = a_q ^ b_q;
        c[0] = 1'b0;
        c[1] = g[0];
        c[2] = g[1] | (p[1] & g[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        cla_sum = {c[4], p ^ c[3:0]};
    end

    // Single conditional subtraction; enough because in-range operands sum to at most 2*MODULUS-2
    always_comb begin
        red_sub  = sum_q - MOD5;
        red_data = (sum_q >= MOD5) ? red_sub[3:0] : sum_q[3:0];
    end

    // Sequencer next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_found) state_d = S_ADD;
            S_ADD:   state_d = S_RED;
            S_RED:   state_d = S_OUT;
            default: if (res_ready) state_d = S_IDLE;
        endcase
    end

    // State, operand capture, result hold and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        a_q    <= req_a[{gnt_id, 2'b00} +: 4];
                        b_q    <= req_b[{gnt_id, 2'b00} +: 4];
                        id_q   <= gnt_id;
                        last_q <= gnt_id;
                    end
                end
                S_ADD: sum_q <= cla_sum;
                S_RED: begin
                    res_data_q  <= red_data;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                end
                default: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                    end
                end
            endcase
        end
    end

`ifdef RNS_RANGE_CHECK_EN
    logic res_err_q;

    // Flag operands that were not residues; lives and dies with res_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_err_q <= 1'b0;
        end else if (state_q == S_RED) begin
            res_err_q <= ({1'b0, a_q} >= MOD5) | ({1'b0, b_q} >= MOD5);
        end else if (state_q == S_OUT && res_ready) begin
            res_err_q <= 1'b0;
        end
    end

    assign res_err = res_err_q;
`endif

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_rns_add_scheduler.sv
// tb/tb_rns_add_scheduler.sv - randomized and directed self-checking bench for rns_add_scheduler
module tb_rns_add_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a, req_b;
    logic        res_valid, res_ready;
    logic [3:0]  res_data;
    logic [1:0]  res_id;
    logic        busy;
    logic [7:0]  op_count;

    logic [3:0]  v16, r16_rdy;
    logic [15:0] a16, b16;
    logic        rv16, rr16, busy16;
    logic [3:0]  rd16;
    logic [1:0]  rid16;
    logic [7:0]  cnt16;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: transaction-level view of the shared adder
    bit m_busy;
    int m_age;
    int m_last;
    int m_count;
    int m_data;
    int m_id;
    int m_err;

`ifdef RNS_RANGE_CHECK_EN
    logic res_err, err16;
    logic [3:0]  v7, r7_rdy;
    logic [15:0] a7, b7;
    logic        rv7, rr7, busy7, err7;
    logic [3:0]  rd7;
    logic [1:0]  rid7;
    logic [7:0]  cnt7;
`endif

    rns_add_scheduler #(.NUM_REQ(4), .ID_W(2), .MODULUS(15)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy), .op_count(op_count)
`ifdef RNS_RANGE_CHECK_EN
        , .res_err(res_err)
`endif
    );

    rns_add_scheduler #(.NUM_REQ(4), .ID_W(2), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst), .req_valid(v16), .req_ready(r16_rdy),
        .req_a(a16), .req_b(b16), .res_valid(rv16), .res_ready(rr16),
        .res_data(rd16), .res_id(rid16), .busy(busy16), .op_count(cnt16)
`ifdef RNS_RANGE_CHECK_EN
        , .res_err(err16)
`endif
    );

`ifdef RNS_RANGE_CHECK_EN
    rns_add_scheduler #(.NUM_REQ(4), .ID_W(2), .MODULUS(7)) dut7 (
        .clk(clk), .rst(rst), .req_valid(v7), .req_ready(r7_rdy),
        .req_a(a7), .req_b(b7), .res_valid(rv7), .res_ready(rr7),
        .res_data(rd7), .res_id(rid7), .busy(busy7), .op_count(cnt7),
        .res_err(err7)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic int mod_add(input int a, input int b, input int m);
        int s;
        s = a + b;
        if (s >= m) s = s - m;
        return s % 16;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_age   = 0;
        m_last  = 3;
        m_count = 0;
    endtask

    // advance the model across one rising edge using the inputs the DUT just sampled
    task automatic model_edge();
        int g, a, b;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            g = rr_pick(req_valid, m_last);
            if (g >= 0) begin
                a      = int'(req_a[4*g +: 4]);
                b      = int'(req_b[4*g +: 4]);
                m_busy = 1'b1;
                m_age  = 0;
                m_last = g;
                m_id   = g;
                m_data = mod_add(a, b, 15);
                m_err  = (a >= 15 || b >= 15) ? 1 : 0;
            end
        end else if (m_age >= 2) begin
            if (res_ready) begin
                m_busy  = 1'b0;
                m_count = (m_count + 1) % 256;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic compare();
        int g, exp_rdy, exp_v;
        g       = rr_pick(req_valid, m_last);
        exp_rdy = (rst || m_busy || g < 0) ? 0 : (1 << g);
        exp_v   = (m_busy && m_age >= 2) ? 1 : 0;
        check_eq("req_ready", int'(req_ready), exp_rdy);
        check_eq("busy", int'(busy), m_busy ? 1 : 0);
        check_eq("res_valid", int'(res_valid), exp_v);
        check_eq("op_count", int'(op_count), m_count);
        if (exp_v == 1) begin
            check_eq("res_data", int'(res_data), m_data);
            check_eq("res_id", int'(res_id), m_id);
`ifdef RNS_RANGE_CHECK_EN
            check_eq("res_err", int'(res_err), m_err);
`endif
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b, input logic r);
        @(posedge clk);
        model_edge();
        #1;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        res_ready = r;
        @(negedge clk);
        compare();
    endtask

    task automatic one_op(input int who, input int a, input int b, input int exp, input string tag);
        logic [15:0] pa, pb;
        pa = '0;
        pb = '0;
        pa[4*who +: 4] = 4'(a);
        pb[4*who +: 4] = 4'(b);
        step(4'(1 << who), pa, pb, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        check_eq(tag, int'(res_data), exp);
        step(4'b0, '0, '0, 1'b1);
        step(4'b0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [3:0]  held_data;
        logic [1:0]  held_id;
        logic [15:0] ra, rb;

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        v16 = '0; a16 = '0; b16 = '0; rr16 = 1'b0;
`ifdef RNS_RANGE_CHECK_EN
        v7 = '0; a7 = '0; b7 = '0; rr7 = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_res_valid", int'(res_valid), 0);
        check_eq("rst_res_data", int'(res_data), 0);
        check_eq("rst_res_id", int'(res_id), 0);
        check_eq("rst_op_count", int'(op_count), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_req_ready", int'(req_ready), 0);
        req_valid = 4'b0000;
        res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // single request 9+8 mod 15
        step(4'b0001, 16'h0009, 16'h0008, 1'b0);
        check_eq("single_grant", int'(req_ready), 1);
        step(4'b0, '0, '0, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        check_eq("single_valid", int'(res_valid), 1);
        check_eq("single_data", int'(res_data), 2);
        check_eq("single_id", int'(res_id), 0);
        step(4'b0, '0, '0, 1'b1);
        step(4'b0, '0, '0, 1'b0);
        check_eq("single_count", int'(op_count), 1);

        // all four requesters, consumer always ready: grants rotate
        for (int i = 0; i < 22; i++) step(4'b1111, 16'h4321, 16'h5678, 1'b1);

        // back-pressure in OUT
        step(4'b0010, 16'h00A0, 16'h0030, 1'b0);
        step(4'b1111, 16'h1111, 16'h2222, 1'b0);
        step(4'b1111, 16'h1111, 16'h2222, 1'b0);
        step(4'b1111, 16'h1111, 16'h2222, 1'b0);
        held_data = res_data;
        held_id   = res_id;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 16'h1111, 16'h2222, 1'b0);
            check_eq("bp_data_stable", int'(res_data), int'(held_data));
            check_eq("bp_id_stable", int'(res_id), int'(held_id));
            check_eq("bp_no_grant", int'(req_ready), 0);
        end
        step(4'b1111, 16'h1111, 16'h2222, 1'b1);
        step(4'b1111, 16'h1111, 16'h2222, 1'b0);
        check_eq("bp_next_grant", (req_ready != 4'b0) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) step(4'b0, '0, '0, 1'b1);

        // boundaries, MODULUS 15
        one_op(2, 7, 7, 14, "bnd_7p7");
        one_op(3, 7, 8, 0, "bnd_7p8");
        one_op(1, 14, 14, 13, "bnd_14p14");

        // randomized traffic, mostly residues with occasional out-of-range operands
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 4; j++) begin
                ra[4*j +: 4] = ($urandom_range(0, 9) == 0) ? 4'(15) : 4'($urandom_range(0, 14));
                rb[4*j +: 4] = ($urandom_range(0, 9) == 0) ? 4'(15) : 4'($urandom_range(0, 14));
            end
            step(4'($urandom_range(0, 15)), ra, rb, ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 5; i++) step(4'b0, '0, '0, 1'b1);

        // reset while in RED
        step(4'b0100, 16'h0500, 16'h0600, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_red_valid", int'(res_valid), 0);
        check_eq("rst_red_busy", int'(busy), 0);
        check_eq("rst_red_count", int'(op_count), 0);
        step(4'b0, '0, '0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(4'b0, '0, '0, 1'b1);
        step(4'b1111, 16'h2222, 16'h3333, 1'b1);
        check_eq("rst_red_prio0", int'(req_ready), 1);
        for (int i = 0; i < 8; i++) step(4'b0, '0, '0, 1'b1);

        // reset while holding a result in OUT: res_valid drops without a clock edge
        step(4'b1000, 16'h4000, 16'h5000, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        step(4'b0, '0, '0, 1'b0);
        check_eq("rst_out_pre_valid", int'(res_valid), 1);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_out_valid", int'(res_valid), 0);
        step(4'b0, '0, '0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(4'b0, '0, '0, 1'b1);

        // MODULUS 16: plain wrap-around
        @(negedge clk);
        v16 = 4'b0001; a16 = 16'h000F; b16 = 16'h0001; rr16 = 1'b0;
        @(posedge clk);
        #1;
        v16 = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("m16_valid", int'(rv16), 1);
        check_eq("m16_data", int'(rd16), 0);
        check_eq("m16_id", int'(rid16), 0);

`ifdef RNS_RANGE_CHECK_EN
        // MODULUS 7 range flag
        @(negedge clk);
        v7 = 4'b0001; a7 = 16'h0009; b7 = 16'h0001; rr7 = 1'b0;
        @(posedge clk);
        #1;
        v7 = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("m7_err_valid", int'(rv7), 1);
        check_eq("m7_err", int'(err7), 1);
        check_eq("m7_err_data", int'(rd7), 3);
        rr7 = 1'b1;
        @(negedge clk);
        rr7 = 1'b0;
        check_eq("m7_err_clear", int'(err7), 0);
        v7 = 4'b0001; a7 = 16'h0003; b7 = 16'h0004;
        @(posedge clk);
        #1;
        v7 = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("m7_ok_valid", int'(rv7), 1);
        check_eq("m7_ok_err", int'(err7), 0);
        check_eq("m7_ok_data", int'(rd7), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
